// File: rtl/stencil_ram_arbiter.sv
// ============================================================================
// Module   : stencil_ram_arbiter
// Brief    : Single-port arbiter for a 1-bit stencil mask RAM: round-robin
//            write/read grants plus a full-RAM fill engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stencil_ram_arbiter #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              i_nrst,
    input  logic              i_clearReq,
    input  logic              i_clearVal,
    output logic              o_clearBusy,
    output logic              o_clearDone,
    input  logic              i_wrReq,
    input  logic [ADDR_W-1:0] i_wrAddr,
    input  logic              i_wrData,
    output logic              o_wrAck,
    input  logic              i_rdReq,
    input  logic [ADDR_W-1:0] i_rdAddr,
    output logic              o_rdAck,
    output logic              o_rdValid,
    output logic              o_rdData,
    output logic [ADDR_W-1:0] o_ramAddrIn,
    output logic [ADDR_W-1:0] o_ramAddrOut,
    output logic              o_ramDataIn,
    output logic              o_ramCs,
    output logic              o_ramWe,
    input  logic              i_ramDataOut
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] c_lastAddr = {ADDR_W{1'b1}};

    state_t              r_state;
    state_t              w_stateNext;
    logic [ADDR_W-1:0]   r_count;
    logic                r_clearVal;
    logic                r_lastRd;
    logic                r_rdValid;

    logic                w_wrGrant;
    logic                w_rdGrant;
    logic                w_clearDone;
    logic                w_ramCs;
    logic                w_ramWe;
    logic                w_ramDataIn;
    logic [ADDR_W-1:0]   w_ramAddrIn;
    logic [ADDR_W-1:0]   w_ramAddrOut;

    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_clearVal <= 1'b0;
            r_lastRd   <= 1'b1;
            r_rdValid  <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_rdValid <= w_rdGrant;
            if (r_state == ST_IDLE && i_clearReq) begin
                r_clearVal <= i_clearVal;
                r_count    <= '0;
            end else if (r_state == ST_CLEAR) begin
                r_count <= r_count + 1'b1;
            end
            if (w_wrGrant)
                r_lastRd <= 1'b0;
            else if (w_rdGrant)
                r_lastRd <= 1'b1;
        end
    end

    always_comb begin
        w_stateNext  = r_state;
        w_wrGrant    = 1'b0;
        w_rdGrant    = 1'b0;
        w_clearDone  = 1'b0;
        w_ramCs      = 1'b0;
        w_ramWe      = 1'b0;
        w_ramDataIn  = 1'b0;
        w_ramAddrIn  = '0;
        w_ramAddrOut = '0;
        case (r_state)
            ST_IDLE: begin
                // A clear request pre-empts both requesters for this cycle
                if (i_clearReq) begin
                    w_stateNext = ST_CLEAR;
                end else if (i_wrReq && i_rdReq) begin
                    w_wrGrant = r_lastRd;
                    w_rdGrant = !r_lastRd;
                end else begin
                    w_wrGrant = i_wrReq;
                    w_rdGrant = i_rdReq;
                end
                if (w_wrGrant) begin
                    w_ramCs     = 1'b1;
                    w_ramWe     = 1'b1;
                    w_ramAddrIn = i_wrAddr;
                    w_ramDataIn = i_wrData;
                end
                if (w_rdGrant) begin
                    w_ramCs      = 1'b1;
                    w_ramAddrOut = i_rdAddr;
                end
            end
            ST_CLEAR: begin
                w_ramCs     = 1'b1;
                w_ramWe     = 1'b1;
                w_ramAddrIn = r_count;
                w_ramDataIn = r_clearVal;
                if (r_count == c_lastAddr) begin
                    w_clearDone = 1'b1;
                    w_stateNext = ST_IDLE;
                end
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    // Combinational outputs are gated so reset silences them immediately
    assign o_wrAck      = i_nrst & w_wrGrant;
    assign o_rdAck      = i_nrst & w_rdGrant;
    assign o_ramCs      = i_nrst & w_ramCs;
    assign o_ramWe      = i_nrst & w_ramWe;
    assign o_ramDataIn  = i_nrst & w_ramDataIn;
    assign o_ramAddrIn  = i_nrst ? w_ramAddrIn  : '0;
    assign o_ramAddrOut = i_nrst ? w_ramAddrOut : '0;
    assign o_clearDone  = i_nrst & w_clearDone;
    assign o_clearBusy  = (r_state == ST_CLEAR);
    assign o_rdValid    = r_rdValid;
    assign o_rdData     = r_rdValid & i_ramDataOut;

endmodule

`default_nettype wire

// File: doc/stencil_ram_arbiter.md
STENCIL_RAM_ARBITER -- requirements
Module: stencil_ram_arbiter

Interface
REQ-001 SHALL have parameter: ADDR_W, default 14, address width of the 1-bit mask RAM (depth = 2^ADDR_W).
REQ-002 SHALL have ports, one per line: name  direction  width  meaning:
- clk  in  1  single clock, all state on rising edge.
- i_nrst  in  1  asynchronous, active-low reset.
- i_clearReq  in  1  single-cycle pulse, starts full-RAM fill.
- i_clearVal  in  1  fill value, captured with i_clearReq.
- o_clearBusy  out  1  fill in progress.
- o_clearDone  out  1  one-cycle pulse on the last fill write.
- i_wrReq  in  1  write request, held until granted.
- i_wrAddr  in  ADDR_W  write address.
- i_wrData  in  1  write data.
- o_wrAck  out  1  write issued to RAM this cycle.
- i_rdReq  in  1  read request, held until granted.
- i_rdAddr  in  ADDR_W  read address.
- o_rdAck  out  1  read issued to RAM this cycle.
- o_rdValid  out  1  o_rdData valid.
- o_rdData  out  1  read result.
- o_ramAddrIn  out  ADDR_W  RAM write address.
- o_ramAddrOut  out  ADDR_W  RAM read address.
- o_ramDataIn  out  1  RAM write data.
- o_ramCs  out  1  RAM chip select.
- o_ramWe  out  1  RAM write enable.
- i_ramDataOut  in  1  RAM registered read data (1-cycle latency after cs=1, we=0).

Function
REQ-003 SHALL issue at most one RAM operation per cycle: write = cs 1, we 1; read = cs 1, we 0; idle = cs 0, we 0.
REQ-004 SHALL implement FSM states IDLE and CLEAR.
REQ-005 IDLE with i_clearReq=1: no grant that cycle; latch i_clearVal; counter to 0; next state CLEAR.
REQ-006 CLEAR: each cycle write latched value at counter address, then increment the counter; no o_wrAck/o_rdAck.
REQ-007 CLEAR: on the write at address 2^ADDR_W-1, assert o_clearDone that cycle; next state IDLE.
REQ-008 o_clearBusy SHALL be 1 exactly during CLEAR cycles (2^ADDR_W cycles).
REQ-009 i_clearReq during CLEAR SHALL be ignored.
REQ-010 IDLE, no i_clearReq, only one request: grant it that cycle (ack combinational).
REQ-011 IDLE, both i_wrReq and i_rdReq: round-robin; grant the one not granted last; the last-grant bit updates only on a grant.
REQ-012 Write grant: o_ramAddrIn=i_wrAddr, o_ramDataIn=i_wrData, o_wrAck=1.
REQ-013 Read grant: o_ramAddrOut=i_rdAddr, o_rdAck=1; o_rdValid=1 and o_rdData=i_ramDataOut exactly the next cycle.
REQ-014 Unused RAM address/data outputs SHALL be 0 in any cycle they are not driving an operation.
REQ-015 A write granted in cycle N followed by a read of the same address in cycle N+1 or later SHALL return the written data.

Reset
REQ-016 i_nrst=0 SHALL asynchronously force the following values:
- state IDLE, counter 0.
- last-grant = read, so write wins the first tie.
- o_clearBusy, o_clearDone, o_rdValid, o_rdData: 0.
- all acks: 0.
- o_ramCs, o_ramWe: 0.
REQ-017 Reset during CLEAR SHALL abort the fill; RAM contents are then undefined; after release, operation resumes from IDLE.

Verification
REQ-018 Bench SHALL cover:
- Fill: clearReq with clearVal=1, ADDR_W=14 -> busy 16384 cycles; addresses 0..16383 each written once; done on address 16383; reading address 5 afterwards -> 1.
- Tie: wrReq and rdReq held 4 cycles after reset -> grant order wr, rd, wr, rd.
- Read-after-write: write address 0x1234 data 1 in cycle N, read address 0x1234 in cycle N+1 -> rdValid at N+2 with data 1.
- Clear vs. requests: clearReq coincident with wrReq and rdReq -> no ack that cycle or during busy; requests granted the cycle after done.
- Mid-clear reset: assert i_nrst=0 at fill address 100 -> busy 0 immediately; cs 0; after release a read is granted in the first cycle.
